router32_tx: RTL and testbench

Transmit-side injector for the 32-bit 4-port router. It accepts destination-tagged words from a single host ready/valid interface and buffers them in per-lane FIFOs. It drains each lane onto that lane's registered addr/data/valid bus, which connects directly to the router's `in_addr`/`in_data`/`in_valid` inputs. A per-lane stall input lets downstream logic throttle any lane independently.

---
 rtl/router32_pkg.sv | 11 +
 rtl/router32_tx_fifo.sv | 38 +++
 rtl/router32_tx.sv | 76 +++++++
 tb/tb_router32_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router32_pkg.sv
// router32_pkg: shared lane widths, port index and FIFO entry types for the router32 transmit injector.
package router32_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_PORTS = 4;
  typedef logic [$clog2(NUM_PORTS)-1:0] port_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
endpackage

// File: rtl/router32_tx_fifo.sv
// router32_tx_fifo: single-lane synchronous FIFO with wrapping pointers and a separate occupancy counter.
module router32_tx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // storage needs no reset: only entries counted by occupancy are ever read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally; occupancy holds when push and pop coincide
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
endmodule

// File: rtl/router32_tx.sv
// router32_tx: host-to-lane demux with per-lane FIFOs and registered tx buses; ROUTER32_TX_STATS_EN adds saturating tx_count.
module router32_tx
  import router32_pkg::*;
#(
  parameter int ADDR_WIDTH = router32_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = router32_pkg::DATA_WIDTH,
  parameter int NUM_PORTS = router32_pkg::NUM_PORTS,
  parameter int FIFO_DEPTH = 4,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            host_valid,
  output logic                            host_ready,
  input  logic [PW-1:0]                   host_port,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [DATA_WIDTH-1:0]           host_data,
  input  logic [NUM_PORTS-1:0]            port_stall,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] tx_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] tx_data,
  output logic [NUM_PORTS-1:0]            tx_valid,
  output logic [NUM_PORTS-1:0]            fifo_full,
  output logic                            idle
`ifdef ROUTER32_TX_STATS_EN
  ,output logic [NUM_PORTS*16-1:0]        tx_count
`endif
);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [NUM_PORTS-1:0] push, pop, empty;
  logic port_ok;
  assign port_ok = 32'(host_port) < NUM_PORTS;
  assign host_ready = !port_ok || !fifo_full[host_port];
  assign idle = &empty && !(|tx_valid);
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    logic [EW-1:0] head;
    logic [CW-1:0] occ;
    logic v_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    assign push[p] = host_valid && host_ready && port_ok && host_port == PW'(p);
    assign pop[p] = occ != '0 && !port_stall[p];
    router32_tx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push[p]),
      .pop(pop[p]),
      .din({host_addr, host_data}),
      .dout(head),
      .full(fifo_full[p]),
      .empty(empty[p]),
      .count(occ)
    );
    // head entry moves into the lane bus on pop; bus holds its value otherwise
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        v_q <= 1'b0;
        a_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= pop[p];
        if (pop[p]) {a_q, d_q} <= head;
      end
    assign tx_valid[p] = v_q;
    assign tx_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = a_q;
    assign tx_data[p*DATA_WIDTH +: DATA_WIDTH] = d_q;
`ifdef ROUTER32_TX_STATS_EN
    logic [15:0] cnt_q;
    // counts every strobe issued on this lane, sticking at all-ones
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (pop[p] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    assign tx_count[p*16 +: 16] = cnt_q;
`endif
  end
endmodule

// File: tb/tb_router32_tx.sv
// tb_router32_tx: directed vector table plus randomized traffic checked against a queue-based lane model.
module tb_router32_tx;
  import router32_pkg::*;
  localparam int NP = 4;
  localparam int DEPTH = 4;
  typedef struct {
    logic v; logic [1:0] port; logic [31:0] addr, data; logic [3:0] stall;
    logic [3:0] e_valid, e_full; logic e_ready, e_idle;
    int lane; logic [31:0] e_addr, e_data;
  } vec_t;
  logic clk = 0, reset = 0, host_valid = 0, host_ready, idle;
  logic [1:0] host_port = 0;
  logic [31:0] host_addr = 0, host_data = 0;
  logic [3:0] port_stall = 0, tx_valid, fifo_full;
  logic [127:0] tx_addr, tx_data;
`ifdef ROUTER32_TX_STATS_EN
  logic [63:0] tx_count;
`endif
  router32_tx dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_port(host_port), .host_addr(host_addr), .host_data(host_data),
    .port_stall(port_stall), .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_valid(tx_valid), .fifo_full(fifo_full), .idle(idle)
`ifdef ROUTER32_TX_STATS_EN
    , .tx_count(tx_count)
`endif
  );
  always #5 clk = ~clk;
  entry_t q[NP][$];
  logic [3:0] m_valid;
  logic [31:0] m_addr[NP], m_data[NP];
  int m_cnt[NP], strobes[NP];
  logic [31:0] got3[$], sent3[$];
  int checks = 0, errs = 0;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit m_ready();
    return q[host_port].size() < DEPTH;
  endfunction
  task automatic m_reset();
    for (int p = 0; p < NP; p++) begin
      q[p].delete();
      m_addr[p] = 0;
      m_data[p] = 0;
      m_cnt[p] = 0;
    end
    m_valid = 0;
  endtask
  task automatic m_edge();
    if (reset) m_reset();
    else begin
      bit acc = host_valid && m_ready();
      for (int p = 0; p < NP; p++)
        if (q[p].size() > 0 && !port_stall[p]) begin
          entry_t e = q[p].pop_front();
          m_valid[p] = 1;
          m_addr[p] = e.addr;
          m_data[p] = e.data;
          if (m_cnt[p] < 65535) m_cnt[p]++;
        end else m_valid[p] = 0;
      if (acc) q[host_port].push_back(entry_t'{addr: host_addr, data: host_data});
    end
  endtask
  task automatic check_model();
    logic [3:0] full_e;
    bit empty_all = 1;
    chk("tx_valid", {60'd0, tx_valid}, {60'd0, m_valid});
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("tx_addr[%0d]", p), {32'd0, tx_addr[p*32 +: 32]}, {32'd0, m_addr[p]});
      chk($sformatf("tx_data[%0d]", p), {32'd0, tx_data[p*32 +: 32]}, {32'd0, m_data[p]});
      full_e[p] = q[p].size() == DEPTH;
      if (q[p].size() != 0) empty_all = 0;
`ifdef ROUTER32_TX_STATS_EN
      chk($sformatf("tx_count[%0d]", p), {48'd0, tx_count[p*16 +: 16]}, 64'(m_cnt[p]));
`endif
      strobes[p] += int'(tx_valid[p]);
    end
    if (tx_valid[3]) got3.push_back(tx_data[96 +: 32]);
    chk("fifo_full", {60'd0, fifo_full}, {60'd0, full_e});
    chk("idle", {63'd0, idle}, {63'd0, empty_all && m_valid == 0});
    chk("host_ready", {63'd0, host_ready}, {63'd0, m_ready()});
  endtask
  task automatic step();
    #1;
    check_model();
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    reset = 1;
    m_reset();
    repeat (n) step();
    reset = 0;
  endtask
  initial begin
    m_reset();
    #1;
    do_reset(2);
    tbl[0]  = '{1, 2, 32'h10,  32'hCAFE0001, 4'h0, 4'h0, 4'h0, 1, 1, -1, 0, 0};
    tbl[1]  = '{0, 0, 0,       0,            4'h0, 4'h0, 4'h0, 1, 0, -1, 0, 0};
    tbl[2]  = '{0, 0, 0,       0,            4'h0, 4'h4, 4'h0, 1, 0, 2, 32'h10, 32'hCAFE0001};
    tbl[3]  = '{1, 0, 32'h100, 32'hD0000000, 4'h1, 4'h0, 4'h0, 1, 1, -1, 0, 0};
    tbl[4]  = '{1, 0, 32'h101, 32'hD0000001, 4'h1, 4'h0, 4'h0, 1, 0, -1, 0, 0};
    tbl[5]  = '{1, 0, 32'h102, 32'hD0000002, 4'h1, 4'h0, 4'h0, 1, 0, -1, 0, 0};
    tbl[6]  = '{1, 0, 32'h103, 32'hD0000003, 4'h1, 4'h0, 4'h0, 1, 0, -1, 0, 0};
    tbl[7]  = '{1, 0, 32'h104, 32'hD0000004, 4'h1, 4'h0, 4'h1, 0, 0, -1, 0, 0};
    tbl[8]  = '{1, 0, 32'h104, 32'hD0000004, 4'h0, 4'h0, 4'h1, 0, 0, -1, 0, 0};
    tbl[9]  = '{0, 0, 0,       0,            4'h0, 4'h1, 4'h0, 1, 0, 0, 32'h100, 32'hD0000000};
    tbl[10] = '{0, 0, 0,       0,            4'h0, 4'h1, 4'h0, 1, 0, 0, 32'h101, 32'hD0000001};
    tbl[11] = '{0, 0, 0,       0,            4'h0, 4'h1, 4'h0, 1, 0, 0, 32'h102, 32'hD0000002};
    tbl[12] = '{0, 0, 0,       0,            4'h0, 4'h1, 4'h0, 1, 0, 0, 32'h103, 32'hD0000003};
    tbl[13] = '{0, 0, 0,       0,            4'h0, 4'h0, 4'h0, 1, 1, -1, 0, 0};
    for (int i = 0; i < 14; i++) begin
      host_valid = tbl[i].v;
      host_port = tbl[i].port;
      host_addr = tbl[i].addr;
      host_data = tbl[i].data;
      port_stall = tbl[i].stall;
      #1;
      chk($sformatf("vec%0d tx_valid", i), {60'd0, tx_valid}, {60'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d fifo_full", i), {60'd0, fifo_full}, {60'd0, tbl[i].e_full});
      chk($sformatf("vec%0d host_ready", i), {63'd0, host_ready}, {63'd0, tbl[i].e_ready});
      chk($sformatf("vec%0d idle", i), {63'd0, idle}, {63'd0, tbl[i].e_idle});
      if (tbl[i].lane >= 0) begin
        chk($sformatf("vec%0d addr", i), {32'd0, tx_addr[tbl[i].lane*32 +: 32]}, {32'd0, tbl[i].e_addr});
        chk($sformatf("vec%0d data", i), {32'd0, tx_data[tbl[i].lane*32 +: 32]}, {32'd0, tbl[i].e_data});
      end
      step();
    end
    port_stall = 4'b0010;
    host_port = 1;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1;
      host_addr = 32'h300 + i;
      host_data = $urandom;
      if (i == 3) begin
        #1;
        do_reset(2);
      end else step();
    end
    host_valid = 0;
    port_stall = 0;
    #1;
    chk("post-reset tx_valid", {60'd0, tx_valid}, 64'd0);
    chk("post-reset idle", {63'd0, idle}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post-reset lane1 quiet %0d", i), {63'd0, tx_valid[1]}, 64'd0);
    end
    for (int p = 0; p < NP; p++) strobes[p] = 0;
    for (int i = 0; i < 8; i++) begin
      host_valid = 1;
      host_port = 2'(i % 4);
      host_addr = 32'h200 + i;
      host_data = $urandom;
      step();
    end
    host_valid = 0;
    repeat (4) step();
    #1;
    chk("interleave idle", {63'd0, idle}, 64'd1);
    for (int p = 0; p < NP; p++) chk($sformatf("interleave strobes[%0d]", p), 64'(strobes[p]), 64'd2);
    got3.delete();
    host_port = 3;
    for (int i = 0; i < 200 && sent3.size() < 10; i++) begin
      bit acc;
      host_valid = 1;
      host_addr = 32'h400 + sent3.size();
      host_data = $urandom;
      port_stall = {1'($urandom % 2), 3'b000};
      acc = m_ready();
      step();
      if (acc) sent3.push_back(host_data);
    end
    host_valid = 0;
    port_stall = 0;
    repeat (8) step();
    chk("wrap count", 64'(got3.size()), 64'd10);
    for (int i = 0; i < 10 && i < got3.size() && i < sent3.size(); i++)
      chk($sformatf("wrap word %0d", i), {32'd0, got3[i]}, {32'd0, sent3[i]});
    for (int i = 0; i < 400; i++) begin
      host_valid = 1'($urandom % 2);
      host_port = 2'($urandom % 4);
      host_addr = $urandom;
      host_data = $urandom;
      for (int p = 0; p < NP; p++) port_stall[p] = ($urandom % 4) == 0;
      step();
    end
    host_valid = 0;
    port_stall = 0;
    repeat (8) step();
    #1;
    chk("random drain idle", {63'd0, idle}, 64'd1);
`ifdef ROUTER32_TX_STATS_EN
    do_reset(2);
    host_valid = 1;
    host_port = 1;
    for (int i = 0; i < 70000; i++) begin
      host_addr = i;
      host_data = ~i;
      step();
    end
    host_valid = 0;
    repeat (4) step();
    #1;
    chk("stats lane1 saturated", {48'd0, tx_count[16 +: 16]}, 64'hFFFF);
    chk("stats lane0", {48'd0, tx_count[0 +: 16]}, 64'd0);
    chk("stats lane2", {48'd0, tx_count[32 +: 16]}, 64'd0);
    chk("stats lane3", {48'd0, tx_count[48 +: 16]}, 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
